// File: rtl/lift_lcd_pkg.sv
// Shared constants for the lift status LCD driver: movement codes, HD44780
// command bytes, display text and the controller state encoding.
// Pure declarations, no logic.
package lift_lcd_pkg;

  // Movement codes as produced by the lift controller
  localparam logic [1:0] MOV_PARADO   = 2'd0;
  localparam logic [1:0] MOV_SUBINDO  = 2'd1;
  localparam logic [1:0] MOV_DESCENDO = 2'd2;
  localparam logic [1:0] MOV_ERRO     = 2'd3;

  // HD44780 command bytes (sent with RS = 0)
  localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display, slow command
  localparam logic [7:0] CMD_ENTRY     = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CMD_LINE1     = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE2     = 8'hC0;  // DDRAM address 0x40

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_DASH  = 8'h2D;

  // 16-character line images, leftmost character in the MSB byte
  localparam logic [127:0] TXT_PARADO   = {"PARADO",   {10{CHAR_SPACE}}};
  localparam logic [127:0] TXT_SUBINDO  = {"SUBINDO",  {9{CHAR_SPACE}}};
  localparam logic [127:0] TXT_DESCENDO = {"DESCENDO", {8{CHAR_SPACE}}};
  localparam logic [127:0] TXT_ERRO     = {"ERRO",     {12{CHAR_SPACE}}};
  localparam logic [127:0] TXT_ANDAR    = {"ANDAR ",   {10{CHAR_SPACE}}};

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_LINE1_ADDR,
    ST_LINE1_CHARS,
    ST_LINE2_ADDR,
    ST_LINE2_CHARS
  } state_t;

  // Phase of the byte currently presented on the LCD pins
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } phase_t;

  // Power-up command list, indexed 0..3
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_8BIT;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lift_lcd_char_rom.sv
// Character lookup for the two display lines from the latched lift status.
// Purely combinational, zero latency.
// No flow control; the caller samples o_char when it loads the next byte.
module lift_lcd_char_rom
  import lift_lcd_pkg::*;
(
  input  logic       i_line,   // 0 = movement line, 1 = floor line
  input  logic [3:0] i_idx,    // column 0..15
  input  logic [1:0] i_mov,
  input  logic [3:0] i_floor,
  output logic [7:0] o_char
);

  logic [127:0] w_txt;
  logic [6:0]   w_sel;

  // Column 0 sits in the top byte, so the bit offset is (15 - idx) * 8
  assign w_sel = {~i_idx, 3'b000};

  // Pick the line image, then substitute the floor digit in column 6 of line 2
  always_comb begin
    w_txt = TXT_ERRO;
    if (i_line) begin
      w_txt = TXT_ANDAR;
    end else begin
      case (i_mov)
        MOV_PARADO:   w_txt = TXT_PARADO;
        MOV_SUBINDO:  w_txt = TXT_SUBINDO;
        MOV_DESCENDO: w_txt = TXT_DESCENDO;
        default:      w_txt = TXT_ERRO;
      endcase
    end

    o_char = w_txt[w_sel +: 8];
    if (i_line && (i_idx == 4'd6)) begin
      o_char = (i_floor <= 4'd8) ? (CHAR_ZERO + {4'd0, i_floor}) : CHAR_DASH;
    end
  end

endmodule

// File: rtl/lift_lcd_status.sv
// Drives a 16x2 HD44780 LCD (8-bit, write-only) with the lift movement and floor.
// Each byte takes 1 setup + EN_PULSE_CYC + wait cycles; a refresh is 34 bytes.
// iUPDATE while busy is remembered as one pending refresh; it never aborts one.
module lift_lcd_status
  import lift_lcd_pkg::*;
#(
  parameter int PWR_WAIT_CYC = 1000000,
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [1:0] iMOVIMENTO,
  input  logic [3:0] iFLOOR,
  input  logic       iUPDATE,
  output logic       oBUSY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  // One shared counter serves the power-up wait and every transfer phase
  localparam int MAX_A   = (PWR_WAIT_CYC > CLR_WAIT_CYC) ? PWR_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);

  state_t           r_state;
  phase_t           r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_idx;
  logic             r_pending;
  logic [1:0]       r_mov;
  logic [3:0]       r_floor;
  logic             r_busy;
  logic [7:0]       r_data;
  logic             r_en;
  logic             r_rs;

  logic [CNT_W-1:0] w_wait_last;
  logic             w_rom_line;
  logic [3:0]       w_rom_idx;
  logic [7:0]       w_char;

  // Clear is the only slow command; everything else uses the short wait
  assign w_wait_last = ((r_data == CMD_CLEAR) && !r_rs) ? CLR_LAST : CMD_LAST;

  // The ROM is addressed with the byte that will be loaded when the current one ends
  assign w_rom_line = (r_state == ST_LINE2_ADDR) || (r_state == ST_LINE2_CHARS);
  assign w_rom_idx  = ((r_state == ST_LINE1_CHARS) || (r_state == ST_LINE2_CHARS))
                      ? (r_idx[3:0] + 4'd1) : 4'd0;

  lift_lcd_char_rom u_char_rom (
    .i_line  (w_rom_line),
    .i_idx   (w_rom_idx),
    .i_mov   (r_mov),
    .i_floor (r_floor),
    .o_char  (w_char)
  );

  assign LCD_DATA = r_data;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = r_en;
  assign LCD_RS   = r_rs;
  assign oBUSY    = r_busy;

  // Controller FSM and byte transfer timer; all LCD pins are registered here
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= ST_PWR_WAIT;
      r_phase   <= PH_SETUP;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pending <= 1'b1;
      r_mov     <= MOV_PARADO;
      r_floor   <= 4'd0;
      r_busy    <= 1'b1;
      r_data    <= 8'h00;
      r_en      <= 1'b0;
      r_rs      <= 1'b0;
    end else begin
      // Strobes outside IDLE coalesce into a single follow-up refresh
      if (iUPDATE && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_PWR_WAIT: begin
          if (r_cnt == PWR_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= init_cmd(2'd0);
            r_rs    <= 1'b0;
            r_phase <= PH_SETUP;
            r_state <= ST_INIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_IDLE: begin
          r_busy <= 1'b0;
          if (r_pending || iUPDATE) begin
            r_mov     <= iMOVIMENTO;
            r_floor   <= iFLOOR;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_data    <= CMD_LINE1;
            r_rs      <= 1'b0;
            r_phase   <= PH_SETUP;
            r_state   <= ST_LINE1_ADDR;
          end
        end

        default: begin
          case (r_phase)
            PH_SETUP: begin
              r_en    <= 1'b1;
              r_cnt   <= '0;
              r_phase <= PH_PULSE;
            end

            PH_PULSE: begin
              if (r_cnt == EN_LAST) begin
                r_en    <= 1'b0;
                r_cnt   <= '0;
                r_phase <= PH_WAIT;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end

            default: begin
              if (r_cnt != w_wait_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
              end else begin
                // Byte finished: present the next one (or stop) in the same cycle
                r_cnt   <= '0;
                r_phase <= PH_SETUP;
                case (r_state)
                  ST_INIT: begin
                    if (r_idx == 5'd3) begin
                      r_busy  <= 1'b0;
                      r_state <= ST_IDLE;
                    end else begin
                      r_idx  <= r_idx + 5'd1;
                      r_data <= init_cmd(r_idx[1:0] + 2'd1);
                      r_rs   <= 1'b0;
                    end
                  end

                  ST_LINE1_ADDR: begin
                    r_idx   <= '0;
                    r_data  <= w_char;
                    r_rs    <= 1'b1;
                    r_state <= ST_LINE1_CHARS;
                  end

                  ST_LINE1_CHARS: begin
                    if (r_idx == 5'd15) begin
                      r_data  <= CMD_LINE2;
                      r_rs    <= 1'b0;
                      r_state <= ST_LINE2_ADDR;
                    end else begin
                      r_idx  <= r_idx + 5'd1;
                      r_data <= w_char;
                    end
                  end

                  ST_LINE2_ADDR: begin
                    r_idx   <= '0;
                    r_data  <= w_char;
                    r_rs    <= 1'b1;
                    r_state <= ST_LINE2_CHARS;
                  end

                  default: begin
                    if (r_idx == 5'd15) begin
                      r_busy  <= 1'b0;
                      r_state <= ST_IDLE;
                    end else begin
                      r_idx  <= r_idx + 5'd1;
                      r_data <= w_char;
                    end
                  end
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/lift_lcd_status.md
Name: lift_lcd_status

Overview:
Consumer end of the lift controller's status interface. Takes the movement code, current floor and an update strobe, and drives the 16x2 HD44780 character LCD in 8-bit write-only mode. It runs the power-up init sequence, then rewrites both display lines whenever the lift controller signals a change. It sits between the lift FSM and the LCD pins of the top level.

Parameters:
PWR_WAIT_CYC, 1000000, cycles held idle after reset before the first command (20 ms at 50 MHz)
EN_PULSE_CYC, 25, LCD_EN high time in cycles (500 ns)
CMD_WAIT_CYC, 2500, wait after LCD_EN falls for a normal command or char (50 us)
CLR_WAIT_CYC, 100000, wait after LCD_EN falls for the clear command 0x01 (2 ms)

Ports:
iCLK  input  1  system clock, 50 MHz
iRST  input  1  asynchronous reset, active-high
iMOVIMENTO  input  2  0 = parado, 1 = subindo, 2 = descendo, 3 = invalid
iFLOOR  input  4  current floor, 0..8 valid
iUPDATE  input  1  single-cycle strobe: status changed, refresh display
oBUSY  output  1  high from reset until init completes, and while a refresh is in progress
LCD_DATA  output  8  LCD data bus
LCD_RW  output  1  tied 0 (write only)
LCD_EN  output  1  LCD enable strobe
LCD_RS  output  1  0 = command, 1 = data

Behaviour:
- Reset: asynchronous assertion forces the following, which also applies on reset mid-operation and restarts from PWR_WAIT.
  - LCD_DATA = 0x00, LCD_EN = 0, LCD_RS = 0, LCD_RW = 0, oBUSY = 1.
  - pending = 1, so the first refresh runs automatically after init.
  - Byte index and counters = 0.
- States: PWR_WAIT, INIT, IDLE, LINE1_ADDR, LINE1_CHARS, LINE2_ADDR, LINE2_CHARS.
- Byte transfer, common to every state that writes. For a byte B:
  - Cycle 0 (SETUP): LCD_DATA = B and LCD_RS are set, LCD_EN = 0.
  - Next EN_PULSE_CYC cycles: LCD_EN = 1.
  - Then LCD_EN = 0 with DATA and RS held for the wait count (CLR_WAIT_CYC if B = 0x01 with RS = 0, otherwise CMD_WAIT_CYC).
  - Byte period: 1 + EN_PULSE_CYC + wait.
  - DATA and RS never change while LCD_EN = 1.
- PWR_WAIT: count PWR_WAIT_CYC cycles, then go to INIT.
- INIT: send commands 0x38, 0x0C, 0x01, 0x06 in that order, then go to IDLE.
- IDLE: oBUSY = 0. When pending = 1 or iUPDATE = 1:
  - Snapshot iMOVIMENTO and iFLOOR into internal registers.
  - Clear pending, set oBUSY = 1, go to LINE1_ADDR.
- LINE1_ADDR: send command 0x80, then 16 data bytes (LINE1_CHARS), index 0..15.
  - mov 0 -> "PARADO"
  - mov 1 -> "SUBINDO"
  - mov 2 -> "DESCENDO"
  - mov 3 -> "ERRO"
  - All are right-padded with spaces (0x20) to 16 characters.
- LINE2_ADDR: send command 0xC0, then 16 data bytes (LINE2_CHARS).
  - Content: "ANDAR " followed by a digit char, padded to 16 characters.
  - Digit = 8'h30 + floor for floor 0..8; floor 9..15 -> '-' (0x2D).
  - After the 16th byte's wait, return to IDLE.
- iUPDATE while oBUSY = 1 (INIT or refresh in progress):
  - Set pending; the current refresh completes with its snapshot (no restart mid-line).
  - Any number of strobes during busy coalesce into one follow-up refresh, which uses the values sampled at the IDLE exit.
- iUPDATE in the same cycle that IDLE exits: treated as the exit trigger; pending is not set again.
- Counters are sized to hold the largest parameter. The byte index is 5 bits and wraps only through the state transition, never by overflow.

Decomposition:
- Package lift_lcd_pkg holds:
  - movimento codes MOV_PARADO = 0, MOV_SUBINDO = 1, MOV_DESCENDO = 2
  - LCD command constants CMD_FUNC_8BIT = 0x38, CMD_DISP_ON = 0x0C, CMD_CLEAR = 0x01, CMD_ENTRY = 0x06, CMD_LINE1 = 0x80, CMD_LINE2 = 0xC0
  - the state enum
- One sub-module, lift_lcd_char_rom: combinational lookup (line, index[3:0], mov, floor) -> char[7:0].
- The transfer timer and FSM stay in lift_lcd_status.

Test Plan:
All scenarios use PWR=10, EN=2, CMD=4, CLR=8 (byte period 7, or 11 for clear).
1. Reset released -> oBUSY = 1. After 10 cycles, four EN pulses with DATA 0x38, 0x0C, 0x01, 0x06 at RS = 0. Then the auto refresh runs: 0x80, 16 chars "PARADO" + spaces, 0xC0, "ANDAR 0"... Then oBUSY = 0 and LCD_RW = 0 throughout.
2. IDLE, mov = 1, floor = 3, one iUPDATE -> line 1 bytes 0x53 0x55 0x42 0x49 0x4E 0x44 0x4F then 0x20 x9. Line 2 byte index 6 = 0x33.
3. Three iUPDATE strobes during a refresh, last with mov = 2, floor = 8 -> exactly one extra refresh, showing "DESCENDO" and '8' (0x38).
4. floor = 12, mov = 3 -> "ERRO" on line 1, line 2 index 6 = 0x2D.
5. iRST pulsed during LINE1_CHARS with LCD_EN high -> LCD_EN = 0 and LCD_DATA = 0 immediately, oBUSY = 1, full PWR_WAIT + INIT sequence repeats.
6. Timing check on every byte: DATA and RS stable from SETUP until EN falls; EN high exactly 2 cycles; gap to the next SETUP = 4 cycles, or 8 cycles after 0x01.
